// File: rtl/crypt_uart_rx_if.sv
// Bus between the UART receiver and the encrypt stage: serial line, key path and plaintext handshake.
// Carries parity_err only when CRYPT_RX_PARITY_EN is defined.
interface crypt_uart_rx_if;
    logic       rx;
    logic       key_reload;
    logic       inp_ready;
    logic [7:0] key;
    logic       key_loaded;
    logic [7:0] inp;
    logic       inp_valid;
    logic       frame_err;
    logic       overrun;
`ifdef CRYPT_RX_PARITY_EN
    logic       parity_err;

    modport master (input rx, key_reload, inp_ready,
                    output key, key_loaded, inp, inp_valid, frame_err, overrun, parity_err);
    modport slave  (output rx, key_reload, inp_ready,
                    input key, key_loaded, inp, inp_valid, frame_err, overrun, parity_err);
`else
    modport master (input rx, key_reload, inp_ready,
                    output key, key_loaded, inp, inp_valid, frame_err, overrun);
    modport slave  (output rx, key_reload, inp_ready,
                    input key, key_loaded, inp, inp_valid, frame_err, overrun);
`endif
endinterface

// File: rtl/crypt_uart_rx.sv
// UART receiver for the 8-bit cryptosystem: first byte (or first after key_reload) is the key, later bytes plaintext.
// Optional macro CRYPT_RX_PARITY_EN switches framing from 8N1 to 8E1 and adds parity_err.
module crypt_uart_rx #(
    parameter int         CLKS_PER_BIT = 104,
    parameter logic [7:0] KEY_RESET    = 8'h00
) (
    input  logic            clk,
    input  logic            rst_n,
    crypt_uart_rx_if.master bus
);
    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_Z   = {CNT_W{1'b0}};
    // Two cycles of the half-bit wait are already spent in the synchronizer.
    localparam logic [CNT_W-1:0] HALF_M2 = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);

`ifdef CRYPT_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3,
                              STOP = 3'd4, WAIT_IDLE = 3'd5} state_t;
    localparam state_t AFTER_DATA = PARITY;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2,
                              STOP = 3'd4, WAIT_IDLE = 3'd5} state_t;
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [2:0]       r_bit, w_bit_nx;
    logic [7:0]       r_shift, w_shift_nx;
    logic             r_sync1, r_sync2;
    logic             w_rx, w_commit, w_ferr, w_par_ok, w_to_key;
    logic [7:0]       r_key, r_inp;
    logic             r_key_loaded, r_inp_valid, r_frame_err, r_overrun;

`ifdef CRYPT_RX_PARITY_EN
    logic r_par_bad, w_par_nx, w_perr, r_parity_err;
    assign w_par_ok       = !r_par_bad;
    assign bus.parity_err = r_parity_err;
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_rx     = r_sync2;
    assign w_to_key = !r_key_loaded || bus.key_reload;

    // Next-state and bit sampling decisions.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_commit   = 1'b0;
        w_ferr     = 1'b0;
`ifdef CRYPT_RX_PARITY_EN
        w_par_nx   = r_par_bad;
        w_perr     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_nx = CNT_Z;
                w_bit_nx = 3'd0;
                if (!w_rx) w_state_nx = START;
                else       w_state_nx = IDLE;
            end
            START: begin
                if (r_cnt == HALF_M2) begin
                    w_cnt_nx = CNT_Z;
                    if (w_rx) w_state_nx = IDLE;
                    else      w_state_nx = DATA;
                end else begin
                    w_state_nx = START;
                end
            end
            DATA: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_nx   = CNT_Z;
                    w_shift_nx = {w_rx, r_shift[7:1]};
                    w_bit_nx   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_nx = AFTER_DATA;
                    else               w_state_nx = DATA;
                end else begin
                    w_state_nx = DATA;
                end
            end
`ifdef CRYPT_RX_PARITY_EN
            PARITY: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_nx   = CNT_Z;
                    w_par_nx   = ^{r_shift, w_rx};
                    w_state_nx = STOP;
                end else begin
                    w_state_nx = PARITY;
                end
            end
`endif
            STOP: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_nx = CNT_Z;
`ifdef CRYPT_RX_PARITY_EN
                    w_perr   = r_par_bad;
`endif
                    if (w_rx) begin
                        w_state_nx = IDLE;
                        w_commit   = w_par_ok;
                    end else begin
                        w_state_nx = WAIT_IDLE;
                        w_ferr     = 1'b1;
                    end
                end else begin
                    w_state_nx = STOP;
                end
            end
            WAIT_IDLE: begin
                w_cnt_nx = CNT_Z;
                if (w_rx) w_state_nx = IDLE;
                else      w_state_nx = WAIT_IDLE;
            end
            default: begin
                w_cnt_nx   = CNT_Z;
                w_state_nx = IDLE;
            end
        endcase
    end

    // Synchronizer and FSM registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= CNT_Z;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
`ifdef CRYPT_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_sync1   <= bus.rx;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_bit     <= w_bit_nx;
            r_shift   <= w_shift_nx;
`ifdef CRYPT_RX_PARITY_EN
            r_par_bad <= w_par_nx;
`endif
        end
    end

    // Commit routing, plaintext handshake and error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key          <= KEY_RESET;
            r_key_loaded   <= 1'b0;
            r_inp          <= 8'h00;
            r_inp_valid    <= 1'b0;
            r_frame_err    <= 1'b0;
            r_overrun      <= 1'b0;
`ifdef CRYPT_RX_PARITY_EN
            r_parity_err   <= 1'b0;
`endif
        end else begin
            r_frame_err <= w_ferr;
`ifdef CRYPT_RX_PARITY_EN
            r_parity_err <= w_perr;
`endif
            if (w_commit && w_to_key) begin
                r_key        <= r_shift;
                r_key_loaded <= 1'b1;
            end else if (bus.key_reload) begin
                r_key_loaded <= 1'b0;
            end else begin
                r_key_loaded <= r_key_loaded;
            end

            if (w_commit && !w_to_key) begin
                if (!r_inp_valid || bus.inp_ready) begin
                    r_inp       <= r_shift;
                    r_inp_valid <= 1'b1;
                end else begin
                    r_overrun   <= 1'b1;
                end
            end else if (r_inp_valid && bus.inp_ready) begin
                r_inp_valid <= 1'b0;
            end else begin
                r_inp_valid <= r_inp_valid;
            end
        end
    end

    assign bus.key        = r_key;
    assign bus.key_loaded = r_key_loaded;
    assign bus.inp        = r_inp;
    assign bus.inp_valid  = r_inp_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_crypt_uart_rx.sv
// Self-checking bench for crypt_uart_rx at CLKS_PER_BIT=8: directed scenarios plus randomized frames
// checked against a byte-level model of key/plaintext routing.
module tb_crypt_uart_rx;
    localparam int C = 8;
`ifdef CRYPT_RX_PARITY_EN
    localparam int LAT = 2 + C / 2 + 10 * C;
`else
    localparam int LAT = 2 + C / 2 + 9 * C;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   n_ferr = 0;
    int   n_valid_hi = 0;
    int   t_valid_rise = 0;
    int   t_key_rise = 0;
    logic prev_valid = 1'b0;
    logic prev_loaded = 1'b0;

    logic [7:0] m_key, m_inp;
    logic       m_loaded, m_valid, m_overrun;

    crypt_uart_rx_if bus ();

    crypt_uart_rx #(.CLKS_PER_BIT(C), .KEY_RESET(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_err) n_ferr <= n_ferr + 1;
        if (bus.inp_valid) n_valid_hi <= n_valid_hi + 1;
        if (bus.inp_valid && !prev_valid) t_valid_rise <= cyc;
        if (bus.key_loaded && !prev_loaded) t_key_rise <= cyc;
        prev_valid  <= bus.inp_valid;
        prev_loaded <= bus.key_loaded;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output int t_fall);
        bus.rx = 1'b0;
        t_fall = cyc;
        idle(C);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            idle(C);
        end
`ifdef CRYPT_RX_PARITY_EN
        bus.rx = ^d;
        idle(C);
`endif
        bus.rx = stop;
        idle(C);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(3);
        checks++; if (bus.key !== 8'h00) begin errors++; $display("FAIL rst_key: got %h want 00", bus.key); end
        checks++; if (bus.key_loaded !== 1'b0) begin errors++; $display("FAIL rst_loaded: got %b want 0", bus.key_loaded); end
        checks++; if (bus.inp !== 8'h00) begin errors++; $display("FAIL rst_inp: got %h want 00", bus.inp); end
        checks++; if (bus.inp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.inp_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b want 0", bus.frame_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", bus.overrun); end
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_key_then_plain;
        int t0, nv;
        bus.inp_ready = 1'b1;
        send_frame(8'h3C, 1'b1, t0);
        idle(4);
        checks++; if (bus.key !== 8'h3C) begin errors++; $display("FAIL key1: got %h want 3c", bus.key); end
        checks++; if (bus.key_loaded !== 1'b1) begin errors++; $display("FAIL loaded1: got %b want 1", bus.key_loaded); end
        checks++; if (t_key_rise - t0 !== LAT) begin errors++; $display("FAIL key_latency: got %0d want %0d", t_key_rise - t0, LAT); end
        checks++; if (bus.inp_valid !== 1'b0) begin errors++; $display("FAIL valid_after_key: got %b want 0", bus.inp_valid); end
        nv = n_valid_hi;
        send_frame(8'hA5, 1'b1, t0);
        idle(4);
        checks++; if (bus.inp !== 8'hA5) begin errors++; $display("FAIL inp1: got %h want a5", bus.inp); end
        checks++; if (n_valid_hi - nv !== 1) begin errors++; $display("FAIL valid_width: got %0d want 1", n_valid_hi - nv); end
        checks++; if (t_valid_rise - t0 !== LAT) begin errors++; $display("FAIL inp_latency: got %0d want %0d", t_valid_rise - t0, LAT); end
        checks++; if (bus.key !== 8'h3C) begin errors++; $display("FAIL key_kept: got %h want 3c", bus.key); end
    endtask

    task automatic test_overrun;
        int t0;
        bus.inp_ready = 1'b0;
        send_frame(8'h00, 1'b1, t0);
        idle(4);
        checks++; if (bus.inp !== 8'h00 || bus.inp_valid !== 1'b1) begin errors++; $display("FAIL ovr_first: got %h/%b want 00/1", bus.inp, bus.inp_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", bus.overrun); end
        send_frame(8'h34, 1'b1, t0);
        idle(4);
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
        checks++; if (bus.inp !== 8'h00) begin errors++; $display("FAIL ovr_hold: got %h want 00", bus.inp); end
        send_frame(8'hAA, 1'b1, t0);
        idle(4);
        checks++; if (bus.inp !== 8'h00 || bus.inp_valid !== 1'b1) begin errors++; $display("FAIL ovr_third: got %h/%b want 00/1", bus.inp, bus.inp_valid); end
        bus.inp_ready = 1'b1;
        idle(1);
        checks++; if (bus.inp_valid !== 1'b0) begin errors++; $display("FAIL ready_drop: got %b want 0", bus.inp_valid); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
    endtask

    task automatic test_glitch;
        int nf, nv;
        nf = n_ferr;
        nv = n_valid_hi;
        bus.rx = 1'b0;
        idle(3);
        bus.rx = 1'b1;
        idle(40);
        checks++; if (n_ferr - nf !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr - nf); end
        checks++; if (n_valid_hi - nv !== 0 || bus.key !== 8'h3C) begin errors++; $display("FAIL glitch_commit: got valid_cycles=%0d key=%h want 0/3c", n_valid_hi - nv, bus.key); end
    endtask

    task automatic test_break;
        int t0, nf;
        nf = n_ferr;
        send_frame(8'hFF, 1'b0, t0);
        idle(40);
        bus.rx = 1'b1;
        idle(10);
        checks++; if (n_ferr - nf !== 1) begin errors++; $display("FAIL break_ferr: got %0d want 1", n_ferr - nf); end
        checks++; if (bus.key !== 8'h3C || bus.inp !== 8'h00) begin errors++; $display("FAIL break_data: got %h/%h want 3c/00", bus.key, bus.inp); end
        send_frame(8'h55, 1'b1, t0);
        idle(4);
        checks++; if (bus.inp !== 8'h55) begin errors++; $display("FAIL after_break: got %h want 55", bus.inp); end
        checks++; if (n_ferr - nf !== 1) begin errors++; $display("FAIL after_break_ferr: got %0d want 1", n_ferr - nf); end
    endtask

    task automatic test_key_reload;
        int t0, nv;
        bus.key_reload = 1'b1;
        idle(1);
        bus.key_reload = 1'b0;
        checks++; if (bus.key_loaded !== 1'b0 || bus.key !== 8'h3C) begin errors++; $display("FAIL reload_pend: got %b/%h want 0/3c", bus.key_loaded, bus.key); end
        nv = n_valid_hi;
        send_frame(8'h5A, 1'b1, t0);
        idle(4);
        checks++; if (bus.key !== 8'h5A || bus.key_loaded !== 1'b1) begin errors++; $display("FAIL reload_key: got %h/%b want 5a/1", bus.key, bus.key_loaded); end
        checks++; if (n_valid_hi - nv !== 0) begin errors++; $display("FAIL reload_no_inp: got %0d want 0", n_valid_hi - nv); end
        send_frame(8'hA5, 1'b1, t0);
        idle(4);
        checks++; if (bus.inp !== 8'hA5) begin errors++; $display("FAIL reload_inp: got %h want a5", bus.inp); end
    endtask

    task automatic test_mid_reset;
        logic [7:0] d;
        d = 8'hF0;
        bus.rx = 1'b0;
        idle(C);
        for (int i = 0; i < 4; i++) begin bus.rx = d[i]; idle(C); end
        bus.rx = d[4];
        idle(3);
        rst_n = 1'b0;
        idle(1);
        checks++; if (bus.key !== 8'h00 || bus.key_loaded !== 1'b0) begin errors++; $display("FAIL mid_rst_key: got %h/%b want 00/0", bus.key, bus.key_loaded); end
        checks++; if (bus.inp !== 8'h00 || bus.inp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_inp: got %h/%b want 00/0", bus.inp, bus.inp_valid); end
        checks++; if (bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got %b/%b want 0/0", bus.overrun, bus.frame_err); end
        rst_n = 1'b1;
        idle(C - 4 + 4 * C);
        idle(60);
        checks++; if (bus.key_loaded !== 1'b0 || bus.inp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_commit: got %b/%b want 0/0", bus.key_loaded, bus.inp_valid); end
    endtask

    task automatic test_random;
        int t0;
        logic [7:0] d;
        logic rdy, rel;
        m_key = 8'h00; m_loaded = 1'b0; m_inp = 8'h00; m_valid = 1'b0; m_overrun = 1'b0;
        for (int n = 0; n < 14; n++) begin
            d   = 8'($urandom);
            rdy = 1'($urandom_range(0, 1));
            rel = ($urandom_range(0, 3) == 0);
            if (rel) begin
                bus.key_reload = 1'b1; idle(1); bus.key_reload = 1'b0; idle(1);
                m_loaded = 1'b0;
            end
            bus.inp_ready = rdy;
            send_frame(d, 1'b1, t0);
            idle(4);
            if (rdy) m_valid = 1'b0;
            if (!m_loaded) begin
                m_key = d; m_loaded = 1'b1;
            end else if (!m_valid) begin
                m_inp = d; m_valid = !rdy;
            end else begin
                m_overrun = 1'b1;
            end
            checks++; if (bus.key !== m_key) begin errors++; $display("FAIL rnd_key[%0d]: got %h want %h", n, bus.key, m_key); end
            checks++; if (bus.key_loaded !== m_loaded) begin errors++; $display("FAIL rnd_loaded[%0d]: got %b want %b", n, bus.key_loaded, m_loaded); end
            checks++; if (bus.inp !== m_inp) begin errors++; $display("FAIL rnd_inp[%0d]: got %h want %h", n, bus.inp, m_inp); end
            checks++; if (bus.inp_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, bus.inp_valid, m_valid); end
            checks++; if (bus.overrun !== m_overrun) begin errors++; $display("FAIL rnd_overrun[%0d]: got %b want %b", n, bus.overrun, m_overrun); end
        end
    endtask

    initial begin
        bus.rx = 1'b1;
        bus.key_reload = 1'b0;
        bus.inp_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_key_then_plain();
        test_overrun();
        test_glitch();
        test_break();
        test_key_reload();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
